// File: rtl/register_file.sv
// 32 x N register file: one write port, two combinational read ports, x00 hardwired to zero.
// Reads go through explicit 32:1 mux trees so the select levels map directly to index bits.

module register_file_mux #(
  parameter int N = 32
) (
  input  logic [4:0]      sel,
  input  logic [32*N-1:0] din,
  output logic [N-1:0]    dout
);

  // Each level halves the candidates; sel[0] picks between neighbours, sel[4] between halves.
  logic [16*N-1:0] lvl4;
  logic [8*N-1:0]  lvl3;
  logic [4*N-1:0]  lvl2;
  logic [2*N-1:0]  lvl1;

  for (genvar j = 0; j < 16; j++) begin : g_l4
    assign lvl4[j*N +: N] = sel[0] ? din[(2*j+1)*N +: N] : din[(2*j)*N +: N];
  end

  for (genvar j = 0; j < 8; j++) begin : g_l3
    assign lvl3[j*N +: N] = sel[1] ? lvl4[(2*j+1)*N +: N] : lvl4[(2*j)*N +: N];
  end

  for (genvar j = 0; j < 4; j++) begin : g_l2
    assign lvl2[j*N +: N] = sel[2] ? lvl3[(2*j+1)*N +: N] : lvl3[(2*j)*N +: N];
  end

  for (genvar j = 0; j < 2; j++) begin : g_l1
    assign lvl1[j*N +: N] = sel[3] ? lvl2[(2*j+1)*N +: N] : lvl2[(2*j)*N +: N];
  end

  assign dout = sel[4] ? lvl1[N +: N] : lvl1[0 +: N];

endmodule

module register_file #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_ena,
  input  logic [4:0]   wr_addr,
  input  logic [N-1:0] wr_data,
  input  logic [4:0]   rd_addr0,
  output logic [N-1:0] rd_data0,
  input  logic [4:0]   rd_addr1,
  output logic [N-1:0] rd_data1
);

  logic [N-1:0]    regs [1:31];
  logic [31:1]     wr_sel;
  logic [32*N-1:0] regs_bus;

  // Address 0 has no enable line, so a write there activates nothing.
  always_comb begin
    wr_sel = '0;
    for (int i = 1; i < 32; i++) begin
      wr_sel[i] = wr_ena && (wr_addr == 5'(i));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 1; i < 32; i++) begin
      if (!rst) begin
        regs[i] <= '0;
      end else if (wr_sel[i]) begin
        regs[i] <= wr_data;
      end
    end
  end

  assign regs_bus[0 +: N] = '0;
  for (genvar k = 1; k < 32; k++) begin : g_bus
    assign regs_bus[k*N +: N] = regs[k];
  end

  register_file_mux #(.N(N)) u_rd_mux0 (
    .sel  (rd_addr0),
    .din  (regs_bus),
    .dout (rd_data0)
  );

  register_file_mux #(.N(N)) u_rd_mux1 (
    .sel  (rd_addr1),
    .din  (regs_bus),
    .dout (rd_data1)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: an array model tracks architectural contents and is
// checked on every falling edge, alongside hand-computed literal expectations.

module tb_register_file;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_ena;
  logic [4:0]   wr_addr;
  logic [N-1:0] wr_data;
  logic [4:0]   rd_addr0;
  logic [N-1:0] rd_data0;
  logic [4:0]   rd_addr1;
  logic [N-1:0] rd_data1;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] mdl [32];
  bit           mdl_valid = 1'b0;

  register_file #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_ena   (wr_ena),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr0 (rd_addr0),
    .rd_data0 (rd_data0),
    .rd_addr1 (rd_addr1),
    .rd_data1 (rd_data1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: reset clears everything, otherwise a nonzero address takes the data.
  always @(posedge clk) begin
    if (rst === 1'b0) begin
      for (int i = 0; i < 32; i++) mdl[i] = '0;
      mdl_valid = 1'b1;
    end else if (wr_ena === 1'b1 && wr_addr != 5'd0) begin
      mdl[wr_addr] = wr_data;
    end
  end

  always @(negedge clk) begin
    if (mdl_valid) begin
      check("model_port0", rd_data0, mdl[rd_addr0]);
      check("model_port1", rd_data1, mdl[rd_addr1]);
    end
  end

  // All input changes happen 1 time unit after a rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [N-1:0] d);
    wr_ena  = 1'b1;
    wr_addr = a;
    wr_data = d;
    next_cycle();
    wr_ena  = 1'b0;
  endtask

  task automatic read_pair(input string name, input logic [4:0] a0, input logic [4:0] a1,
                           input logic [N-1:0] e0, input logic [N-1:0] e1);
    rd_addr0 = a0;
    rd_addr1 = a1;
    #2;
    check({name, "_p0"}, rd_data0, e0);
    check({name, "_p1"}, rd_data1, e1);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b0;
    wr_ena   = 1'b1;
    wr_addr  = 5'd5;
    wr_data  = 32'hDEADBEEF;
    rd_addr0 = 5'd0;
    rd_addr1 = 5'd0;
    next_cycle();
    next_cycle();

    // Reset held with a pending write: everything reads zero.
    for (int a = 0; a < 32; a++) begin
      read_pair("reset_sweep", 5'(a), 5'(31 - a), 32'h0, 32'h0);
    end

    rst    = 1'b1;
    wr_ena = 1'b0;
    next_cycle();
    read_pair("after_reset_x5", 5'd5, 5'd5, 32'h0, 32'h0);

    for (int i = 1; i < 32; i++) begin
      write(5'(i), 32'h1000_0000 + i);
    end
    for (int a = 0; a < 32; a++) begin
      read_pair("full_sweep", 5'(a), 5'(a),
                (a == 0) ? 32'h0 : 32'h1000_0000 + a,
                (a == 0) ? 32'h0 : 32'h1000_0000 + a);
    end
    read_pair("sweep_cross", 5'd1, 5'd31, 32'h1000_0001, 32'h1000_001F);

    write(5'd0, 32'hFFFFFFFF);
    read_pair("x0_protect", 5'd0, 5'd0, 32'h0, 32'h0);

    // Read-during-write: old value until the edge, new value after.
    write(5'd7, 32'hA5A5A5A5);
    rd_addr0 = 5'd7;
    rd_addr1 = 5'd7;
    wr_ena   = 1'b1;
    wr_addr  = 5'd7;
    wr_data  = 32'h5A5A5A5A;
    #2;
    check("rdw_before", rd_data0, 32'hA5A5A5A5);
    next_cycle();
    wr_ena = 1'b0;
    check("rdw_after", rd_data0, 32'h5A5A5A5A);
    check("rdw_after_p1", rd_data1, 32'h5A5A5A5A);
    next_cycle();

    wr_ena  = 1'b0;
    wr_addr = 5'd9;
    wr_data = 32'h12345678;
    next_cycle();
    read_pair("disabled_write", 5'd9, 5'd9, 32'h1000_0009, 32'h1000_0009);

    write(5'd22, 32'hCAFE0016);
    write(5'd6, 32'hCAFE0006);
    read_pair("top_half", 5'd22, 5'd6, 32'hCAFE0016, 32'hCAFE0006);
    read_pair("top_half_swap", 5'd6, 5'd22, 32'hCAFE0006, 32'hCAFE0016);
    read_pair("same_reg", 5'd13, 5'd13, 32'h1000_000D, 32'h1000_000D);

    // Reset mid-sequence wins over a simultaneous write; the next write lands normally.
    wr_ena  = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'h33333333;
    rst     = 1'b0;
    next_cycle();
    rst    = 1'b1;
    wr_ena = 1'b0;
    read_pair("mid_reset", 5'd3, 5'd22, 32'h0, 32'h0);
    write(5'd3, 32'h44444444);
    read_pair("post_reset_write", 5'd3, 5'd7, 32'h44444444, 32'h0);

    next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
